// File: rtl/encoder_pkg.sv
// Shared types and constants for the encoder measurement-window controller.
package encoder_pkg;

    localparam int ENC_CNT_W          = 16;
    localparam int ENC_DEFAULT_PERIOD = 1250000;
    localparam int MIN_PERIOD         = 2;

    typedef enum logic {IDLE, RUN} win_state_e;
    typedef enum logic {RD_IDLE, RD_ACK} rd_state_e;

    // A window shorter than two cycles would leave no cycle with cnt_clear low.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : p;
    endfunction

endpackage

// File: rtl/encoder_window_timer.sv
// Window sequencer: period register, active-period copy, timer and the
// registered clear / end-of-window strobes.
module encoder_window_timer
    import encoder_pkg::*;
#(
    parameter int DEFAULT_PERIOD = ENC_DEFAULT_PERIOD
) (
    input  logic        clk,
    input  logic        resetCounters,
    input  logic [31:0] cfg_period,
    input  logic        cfg_load,
    input  logic        cfg_enable,
    output logic        cnt_clear,
    output logic        window_tick
);

    win_state_e  state, state_n;
    logic [31:0] period_reg;
    logic [31:0] active_period, active_n;
    logic [31:0] timer, timer_n;
    logic        end_n;

    always_ff @(posedge clk or posedge resetCounters) begin
        if (resetCounters)
            period_reg <= clamp_period(32'(DEFAULT_PERIOD));
        else if (cfg_load)
            period_reg <= clamp_period(cfg_period);
    end

    // period_reg is only copied into active_period at a window start, so a
    // load never alters the window in progress.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        active_n = active_period;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (cfg_enable) begin
                    state_n  = RUN;
                    active_n = period_reg;
                end
            end
            RUN: begin
                if (!cfg_enable) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else if (timer == active_period - 32'd1) begin
                    timer_n  = '0;
                    active_n = period_reg;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            default: ;
        endcase
        // Strobes are computed one cycle ahead so they can leave a flop.
        end_n = (state_n == RUN) && (timer_n == active_n - 32'd1);
    end

    always_ff @(posedge clk or posedge resetCounters) begin
        if (resetCounters) begin
            state         <= IDLE;
            timer         <= '0;
            active_period <= clamp_period(32'(DEFAULT_PERIOD));
            cnt_clear     <= 1'b1;
            window_tick   <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            active_period <= active_n;
            cnt_clear     <= (state_n == IDLE) || end_n;
            window_tick   <= end_n;
        end
    end

endmodule

// File: rtl/encoder_window_ctrl.sv
// Encoder window controller: snapshots all channel counts at each window end
// and serves them over a 4-phase req/ack read port with fresh/overrun flags.
module encoder_window_ctrl
    import encoder_pkg::*;
#(
    parameter int NCH            = 4,
    parameter int CNT_W          = ENC_CNT_W,
    parameter int DEFAULT_PERIOD = ENC_DEFAULT_PERIOD
) (
    input  logic                    clk,
    input  logic                    resetCounters,
    input  logic [31:0]             cfg_period,
    input  logic                    cfg_load,
    input  logic                    cfg_enable,
    input  logic [NCH*CNT_W-1:0]    cnt_in,
    output logic                    cnt_clear,
    output logic                    window_tick,
    input  logic                    rd_req,
    input  logic [$clog2(NCH)-1:0]  rd_ch,
    output logic                    rd_ack,
    output logic [CNT_W-1:0]        rd_data,
    output logic                    rd_fresh,
    output logic                    rd_overrun,
    output logic [NCH-1:0]          fresh
);

    localparam int CH_W = $clog2(NCH);

    logic [NCH-1:0][CNT_W-1:0] cnt_arr;
    logic [NCH-1:0][CNT_W-1:0] snap;
    logic [NCH-1:0]            overrun;
    logic [NCH-1:0]            ack_vec;
    rd_state_e                 rd_st, rd_st_n;
    logic                      accept;

    assign cnt_arr = cnt_in;

    encoder_window_timer #(
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_timer (
        .clk           (clk),
        .resetCounters (resetCounters),
        .cfg_period    (cfg_period),
        .cfg_load      (cfg_load),
        .cfg_enable    (cfg_enable),
        .cnt_clear     (cnt_clear),
        .window_tick   (window_tick)
    );

    // Leaving RD_ACK needs rd_req low, which also guarantees the one low
    // cycle required before the next request is accepted.
    always_comb begin
        rd_st_n = rd_st;
        accept  = 1'b0;
        case (rd_st)
            RD_IDLE: begin
                if (rd_req) begin
                    accept  = 1'b1;
                    rd_st_n = RD_ACK;
                end
            end
            RD_ACK: begin
                if (!rd_req)
                    rd_st_n = RD_IDLE;
            end
            default: ;
        endcase
    end

    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NCH; i++)
            ack_vec[i] = accept && (rd_ch == CH_W'(i));
    end

    assign rd_ack = (rd_st == RD_ACK);

    always_ff @(posedge clk or posedge resetCounters) begin
        if (resetCounters) begin
            rd_st      <= RD_IDLE;
            rd_data    <= '0;
            rd_fresh   <= 1'b0;
            rd_overrun <= 1'b0;
        end else begin
            rd_st <= rd_st_n;
            if (accept) begin
                rd_data    <= snap[rd_ch];
                rd_fresh   <= fresh[rd_ch];
                rd_overrun <= overrun[rd_ch];
            end
        end
    end

    // A snapshot landing on the ack edge wins for fresh; the ack still
    // consumes the old value, so overrun restarts from zero.
    always_ff @(posedge clk or posedge resetCounters) begin
        if (resetCounters) begin
            snap    <= '0;
            fresh   <= '0;
            overrun <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (window_tick) begin
                    snap[i]    <= cnt_arr[i];
                    fresh[i]   <= 1'b1;
                    overrun[i] <= fresh[i] && !ack_vec[i];
                end else if (ack_vec[i]) begin
                    fresh[i]   <= 1'b0;
                    overrun[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_encoder_window_ctrl.sv
// Bench for encoder_window_ctrl: directed window/read scenarios plus random
// traffic, all checked every cycle against a deadline-based reference model.
module tb_encoder_window_ctrl;

    localparam int NCH     = 4;
    localparam int CNT_W   = 16;
    localparam int DEF_PER = 40;
    localparam int CH_W    = 2;

    logic                   clk = 1'b0;
    logic                   resetCounters = 1'b1;
    logic [31:0]            cfg_period = '0;
    logic                   cfg_load = 1'b0;
    logic                   cfg_enable = 1'b0;
    logic [NCH*CNT_W-1:0]   cnt_in = '0;
    logic                   cnt_clear, window_tick;
    logic                   rd_req = 1'b0;
    logic [CH_W-1:0]        rd_ch = '0;
    logic                   rd_ack;
    logic [CNT_W-1:0]       rd_data;
    logic                   rd_fresh, rd_overrun;
    logic [NCH-1:0]         fresh;

    encoder_window_ctrl #(
        .NCH            (NCH),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF_PER)
    ) dut (
        .clk           (clk),
        .resetCounters (resetCounters),
        .cfg_period    (cfg_period),
        .cfg_load      (cfg_load),
        .cfg_enable    (cfg_enable),
        .cnt_in        (cnt_in),
        .cnt_clear     (cnt_clear),
        .window_tick   (window_tick),
        .rd_req        (rd_req),
        .rd_ch         (rd_ch),
        .rd_ack        (rd_ack),
        .rd_data       (rd_data),
        .rd_fresh      (rd_fresh),
        .rd_overrun    (rd_overrun),
        .fresh         (fresh)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: windows are tracked as absolute deadlines (cycle of the
    // next expected tick), reads as the abstract 4-phase handshake.
    bit               m_run;
    int               m_tick_at;
    int               m_per;
    logic [CNT_W-1:0] m_snap [NCH];
    bit               m_fresh [NCH];
    bit               m_ovr [NCH];
    bit               m_ack;
    logic [CNT_W-1:0] m_rd_data;
    bit               m_rd_fresh, m_rd_ovr;

    function automatic void model_reset();
        m_run = 0; m_tick_at = -1; m_per = DEF_PER; m_ack = 0;
        m_rd_data = '0; m_rd_fresh = 0; m_rd_ovr = 0;
        for (int i = 0; i < NCH; i++) begin
            m_snap[i] = '0; m_fresh[i] = 0; m_ovr[i] = 0;
        end
    endfunction

    // Applies one clock edge: cycle 'cyc' ends, cycle cyc+1 begins.
    function automatic void model_edge();
        bit p_tick = m_run && (cyc == m_tick_at);
        bit acc    = rd_req && !m_ack;
        if (acc) begin
            m_rd_data  = m_snap[rd_ch];
            m_rd_fresh = m_fresh[rd_ch];
            m_rd_ovr   = m_ovr[rd_ch];
        end
        for (int i = 0; i < NCH; i++) begin
            bit hit = acc && (int'(rd_ch) == i);
            if (p_tick) begin
                m_ovr[i]   = m_fresh[i] && !hit;
                m_fresh[i] = 1;
                m_snap[i]  = cnt_in[i*CNT_W +: CNT_W];
            end else if (hit) begin
                m_fresh[i] = 0;
                m_ovr[i]   = 0;
            end
        end
        if (acc)          m_ack = 1;
        else if (!rd_req) m_ack = 0;
        if (!m_run) begin
            if (cfg_enable) begin
                m_run     = 1;
                m_tick_at = cyc + m_per;
            end
        end else if (!cfg_enable) begin
            m_run = 0;
        end else if (p_tick) begin
            m_tick_at = cyc + m_per;
        end
        if (cfg_load) m_per = (cfg_period < 2) ? 2 : int'(cfg_period);
    endfunction

    task automatic step();
        logic [NCH-1:0] fm;
        bit             tk;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        tk = m_run && (cyc == m_tick_at);
        for (int i = 0; i < NCH; i++) fm[i] = m_fresh[i];
        chk("window_tick", 32'(window_tick), 32'(tk));
        chk("cnt_clear",   32'(cnt_clear),   32'(!m_run || tk));
        chk("rd_ack",      32'(rd_ack),      32'(m_ack));
        chk("rd_data",     32'(rd_data),     32'(m_rd_data));
        chk("rd_fresh",    32'(rd_fresh),    32'(m_rd_fresh));
        chk("rd_overrun",  32'(rd_overrun),  32'(m_rd_ovr));
        chk("fresh",       32'(fresh),       32'(fm));
    endtask

    task automatic wait_tick(input int budget, output int t);
        t = -1;
        for (int n = 0; n < budget; n++) begin
            step();
            if (window_tick) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic rd(input int ch, output logic [CNT_W-1:0] d, output logic f, output logic o);
        bit got = 0;
        rd_ch  = CH_W'(ch);
        rd_req = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            if (rd_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("rd_ack_timeout", 32'd0, 32'd1);
        d = rd_data; f = rd_fresh; o = rd_overrun;
        rd_req = 1'b0;
        for (int n = 0; n < 8 && rd_ack; n++) step();
        if (rd_ack) chk("rd_drop_timeout", 32'd0, 32'd1);
    endtask

    task automatic load(input int p);
        cfg_period = 32'(p);
        cfg_load   = 1'b1;
        step();
        cfg_load   = 1'b0;
    endtask

    function automatic void set_ch(input int ch, input int v);
        cnt_in[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endfunction

    function automatic void rand_cnt();
        for (int i = 0; i < NCH; i++) cnt_in[i*CNT_W +: CNT_W] = CNT_W'($urandom);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               t0, t1, t2, t3, t4, t5, t6, t7, run_start, nt;
        logic [CNT_W-1:0] d, exp3;
        logic             f, o;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt_clear",   32'(cnt_clear),   32'd1);
        chk("rst_window_tick", 32'(window_tick), 32'd0);
        chk("rst_rd_ack",      32'(rd_ack),      32'd0);
        chk("rst_rd_data",     32'(rd_data),     32'd0);
        chk("rst_fresh",       32'(fresh),       32'd0);
        resetCounters = 1'b0;
        model_reset();
        repeat (3) step();

        // Default period: first tick on RUN cycle DEF_PER, snapshot = cnt_in then
        cfg_enable = 1'b1;
        step();
        run_start = cyc;
        t1 = -1;
        exp3 = '0;
        for (int n = 0; n < 100; n++) begin
            rand_cnt();
            step();
            if (window_tick) begin
                t1 = cyc;
                exp3 = cnt_in[3*CNT_W +: CNT_W];
                break;
            end
        end
        if (t1 < 0) chk("first_tick_timeout", 32'd0, 32'd1);
        chk("first_tick_run_cycle", 32'(t1 - run_start + 1), 32'(DEF_PER));
        step();
        rd(3, d, f, o);
        chk("snap_default_data",  32'(d), 32'(exp3));
        chk("snap_default_fresh", 32'(f), 32'd1);

        // Period changes take effect at the next window only; 0 clamps to 2
        load(20);
        wait_tick(100, t2);
        chk("no_shorten_40", 32'(t2 - t1), 32'd40);
        repeat (5) step();
        load(10);
        wait_tick(100, t3);
        chk("no_shorten_20", 32'(t3 - t2), 32'd20);
        wait_tick(100, t4);
        chk("period_10", 32'(t4 - t3), 32'd10);
        load(0);
        wait_tick(100, t5);
        chk("old_period_10", 32'(t5 - t4), 32'd10);
        wait_tick(100, t6);
        chk("clamp_2a", 32'(t6 - t5), 32'd2);
        wait_tick(100, t7);
        chk("clamp_2b", 32'(t7 - t6), 32'd2);

        // Settle into 30-cycle windows for the read scenarios
        load(30);
        repeat (3) wait_tick(100, t0);
        step();

        // Counts 100/200/300/400: fresh then stale read of ch2
        set_ch(0, 100); set_ch(1, 200); set_ch(2, 300); set_ch(3, 400);
        wait_tick(100, t0);
        step();
        rd(2, d, f, o);
        chk("ch2_data",        32'(d), 32'd300);
        chk("ch2_fresh",       32'(f), 32'd1);
        rd(2, d, f, o);
        chk("ch2_again_data",  32'(d), 32'd300);
        chk("ch2_again_fresh", 32'(f), 32'd0);

        // Two snapshots of ch0 unread: overrun reported once
        set_ch(0, 1111);
        wait_tick(100, t0);
        step();
        set_ch(0, 2222);
        wait_tick(100, t0);
        step();
        rd(0, d, f, o);
        chk("ovr_data",       32'(d), 32'd2222);
        chk("ovr_flag",       32'(o), 32'd1);
        rd(0, d, f, o);
        chk("ovr_next_flag",  32'(o), 32'd0);
        chk("ovr_next_fresh", 32'(f), 32'd0);

        // Read of ch1 accepted on the snapshot edge returns the old value
        set_ch(1, 5555);
        wait_tick(100, t0);
        rd(1, d, f, o);
        chk("same_edge_old", 32'(d), 32'd200);
        chk("same_edge_fresh_kept", 32'(fresh[1]), 32'd1);

        // Disable mid-window: no ticks, clear held, snapshots retained
        repeat (5) step();
        cfg_enable = 1'b0;
        nt = 0;
        for (int n = 0; n < 50; n++) begin
            step();
            if (window_tick) nt++;
        end
        chk("disabled_ticks", 32'(nt), 32'd0);
        chk("disabled_clear", 32'(cnt_clear), 32'd1);
        rd(1, d, f, o);
        chk("retained_data",  32'(d), 32'd5555);
        chk("retained_fresh", 32'(f), 32'd1);

        // Asynchronous reset mid-window
        cfg_enable = 1'b1;
        repeat (10) step();
        #2 resetCounters = 1'b1;
        #1;
        chk("arst_cnt_clear",   32'(cnt_clear),   32'd1);
        chk("arst_window_tick", 32'(window_tick), 32'd0);
        chk("arst_rd_ack",      32'(rd_ack),      32'd0);
        chk("arst_rd_data",     32'(rd_data),     32'd0);
        chk("arst_rd_fresh",    32'(rd_fresh),    32'd0);
        chk("arst_rd_overrun",  32'(rd_overrun),  32'd0);
        chk("arst_fresh",       32'(fresh),       32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        resetCounters = 1'b0;
        model_reset();

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic r;
            rand_cnt();
            r = 1'($urandom_range(0, 1));
            if (!rd_req && r) rd_ch = CH_W'($urandom_range(0, NCH - 1));
            rd_req = r;
            cfg_load = ($urandom_range(0, 29) == 0);
            if (cfg_load) cfg_period = 32'($urandom_range(0, 12));
            if (cfg_enable && $urandom_range(0, 79) == 0)       cfg_enable = 1'b0;
            else if (!cfg_enable && $urandom_range(0, 3) == 0)  cfg_enable = 1'b1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
